i2c_bus_monitor: RTL and testbench

- Passive I2C bus decoder. Samples raw SCL/SDA levels and reports START, repeated START, STOP, completed bytes (with ACK/NACK), R/W direction and framing errors as single-cycle event pulses.
- Sits directly upstream of the bus assertion/coverage checker. The checker consumes these decoded events instead of raw edges, and the monitor is also instantiable in the DUT for debug.
- Never drives the bus.

---
 rtl/i2c_mon_pkg.sv | 23 ++
 rtl/i2c_sync_filter.sv | 43 ++++
 rtl/i2c_bus_monitor.sv | 173 +++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C bus monitor and the checker that consumes its events.
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } mon_state_e;

  localparam int unsigned BIT_CNT_W = 4;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef struct packed {
    logic start;
    logic rstart;
    logic stop;
    logic byte_valid;
    logic bus_err;
  } mon_evt_t;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchronizer plus stability filter for one raw bus line; idles high.
module i2c_sync_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o,
  output logic filt_d_o
);

  localparam int unsigned CNT_W = 4;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      filt_o   <= 1'b1;
      filt_d_o <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1    <= line_i;
      sync2    <= sync1;
      filt_d_o <= filt_o;
      // Level only moves after FILTER_LEN consecutive disagreeing samples.
      if (sync2 != filt_o) begin
        if (cnt == CNT_W'(FILTER_LEN - 1)) begin
          filt_o <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C decoder: turns filtered SCL/SDA into registered START/STOP/byte event pulses.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       start_o,
  output logic       rstart_o,
  output logic       stop_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       is_addr_o,
  output logic       rw_o,
  output logic       ack_o,
  output logic       bus_err_o,
  output logic       busy_o
);

  logic rst_meta;
  logic rst_n_s;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rst_meta <= 1'b0;
      rst_n_s  <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n_s  <= rst_meta;
    end
  end

  logic scl_f, scl_d, sda_f, sda_d;

  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .pclk     (pclk),
    .rst_n    (rst_n_s),
    .line_i   (scl_i),
    .filt_o   (scl_f),
    .filt_d_o (scl_d)
  );

  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .pclk     (pclk),
    .rst_n    (rst_n_s),
    .line_i   (sda_i),
    .filt_o   (sda_f),
    .filt_d_o (sda_d)
  );

  logic scl_hold, start_det, stop_det, scl_rise, scl_fall;

  assign scl_hold  = scl_f & scl_d;
  assign start_det = scl_hold & sda_d & ~sda_f;
  assign stop_det  = scl_hold & ~sda_d & sda_f;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;

  mon_state_e           state, state_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]           shreg, shreg_n;
  logic                 pend, pend_n;
  logic                 busy_q, busy_n;
  logic [7:0]           byte_q, byte_n;
  logic                 is_addr_q, is_addr_n;
  logic                 rw_q, rw_n;
  logic                 ack_q, ack_n;
  mon_evt_t             evt_q, evt_n;
  logic                 frame_err;

  always_ff @(posedge pclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      pend      <= 1'b0;
      busy_q    <= 1'b0;
      byte_q    <= '0;
      is_addr_q <= 1'b0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      evt_q     <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      pend      <= pend_n;
      busy_q    <= busy_n;
      byte_q    <= byte_n;
      is_addr_q <= is_addr_n;
      rw_q      <= rw_n;
      ack_q     <= ack_n;
      evt_q     <= evt_n;
    end
  end

  // The SCL rise that sets up a STOP/rSTART is sampled like any bit; it is not a
  // completed bit, so the sample still inside the current SCL-high phase is excluded.
  assign frame_err = (state != IDLE) &&
                     (pend ? (bit_cnt >= BIT_CNT_W'(2)) : (bit_cnt != '0));

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    pend_n    = pend;
    busy_n    = busy_q;
    byte_n    = byte_q;
    is_addr_n = is_addr_q;
    rw_n      = rw_q;
    ack_n     = ack_q;
    evt_n     = '0;

    if (start_det) begin
      if (state == IDLE) begin
        evt_n.start = 1'b1;
      end else begin
        evt_n.rstart  = 1'b1;
        evt_n.bus_err = frame_err;
      end
      state_n   = ADDR;
      busy_n    = 1'b1;
      bit_cnt_n = '0;
      shreg_n   = '0;
      pend_n    = 1'b0;
    end else if (stop_det) begin
      evt_n.stop    = 1'b1;
      evt_n.bus_err = frame_err;
      state_n       = IDLE;
      busy_n        = 1'b0;
      bit_cnt_n     = '0;
      shreg_n       = '0;
      pend_n        = 1'b0;
    end else begin
      if (scl_fall) begin
        pend_n = 1'b0;
      end
      if (scl_rise && (state != IDLE)) begin
        pend_n = 1'b1;
        if (bit_cnt == BIT_CNT_W'(8)) begin
          evt_n.byte_valid = 1'b1;
          byte_n    = shreg;
          ack_n     = sda_f;
          is_addr_n = (state == ADDR);
          if (state == ADDR) begin
            rw_n    = shreg[0];
            state_n = DATA;
          end
          bit_cnt_n = '0;
          shreg_n   = '0;
        end else begin
          shreg_n   = {shreg[6:0], sda_f};
          bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign start_o      = evt_q.start;
  assign rstart_o     = evt_q.rstart;
  assign stop_o       = evt_q.stop;
  assign byte_valid_o = evt_q.byte_valid;
  assign bus_err_o    = evt_q.bus_err;
  assign byte_o       = byte_q;
  assign is_addr_o    = is_addr_q;
  assign rw_o         = rw_q;
  assign ack_o        = ack_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Randomized bench: raw bus waveforms scored against a transaction-level event model.
module tb_i2c_bus_monitor;

  localparam int unsigned FL = 3;
  localparam int H = FL + 5;
  localparam int Q = H / 2;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       scl_i, sda_i;
  logic       start_o, rstart_o, stop_o, byte_valid_o;
  logic [7:0] byte_o;
  logic       is_addr_o, rw_o, ack_o, bus_err_o, busy_o;

  i2c_bus_monitor #(.FILTER_LEN(FL)) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .start_o      (start_o),
    .rstart_o     (rstart_o),
    .stop_o       (stop_o),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o),
    .is_addr_o    (is_addr_o),
    .rw_o         (rw_o),
    .ack_o        (ack_o),
    .bus_err_o    (bus_err_o),
    .busy_o       (busy_o)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    int         t;
    logic       start, rstart, stop, bv, err;
    logic [7:0] data;
    logic       is_addr, ack, rw, busy;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge pclk) begin
    ev_t o;
    #1;
    if (start_o | rstart_o | stop_o | byte_valid_o | bus_err_o) begin
      o.t = cyc; o.start = start_o; o.rstart = rstart_o; o.stop = stop_o;
      o.bv = byte_valid_o; o.err = bus_err_o; o.data = byte_o;
      o.is_addr = is_addr_o; o.ack = ack_o; o.rw = rw_o; o.busy = busy_o;
      obs_q.push_back(o);
    end
  end

  // Protocol model: bus state, captured bits of the current byte, and whether the
  // newest bit's SCL-high phase is still open (such a bit is not yet completed).
  bit m_busy = 0, m_pend = 0, m_addr = 0, m_rw = 0;
  bit bitq[$];
  bit cur_scl, cur_sda;

  task automatic model_edge(input bit ps, input bit pd, input bit ns, input bit nd);
    ev_t e;
    bit  push = 0;
    int  done_bits;
    e.t = cyc + 3 + int'(FL);
    e.start = 0; e.rstart = 0; e.stop = 0; e.bv = 0; e.err = 0;
    e.data = '0; e.is_addr = 0; e.ack = 0;
    done_bits = bitq.size() - (m_pend ? 1 : 0);
    if (ps && ns && pd && !nd) begin
      if (m_busy) begin
        e.rstart = 1;
        e.err = (done_bits > 0);
      end else begin
        e.start = 1;
      end
      m_busy = 1; m_addr = 1; m_pend = 0; bitq.delete(); push = 1;
    end else if (ps && ns && !pd && nd) begin
      e.stop = 1;
      e.err = m_busy && (done_bits > 0);
      m_busy = 0; m_pend = 0; bitq.delete(); push = 1;
    end else if (ps && !ns) begin
      m_pend = 0;
    end else if (!ps && ns && m_busy) begin
      bitq.push_back(nd);
      m_pend = 1;
      if (bitq.size() == 9) begin
        e.bv = 1;
        e.ack = nd;
        for (int i = 0; i < 8; i++) e.data = {e.data[6:0], bitq[i]};
        e.is_addr = m_addr;
        if (m_addr) m_rw = e.data[0];
        m_addr = 0;
        bitq.delete();
        push = 1;
      end
    end
    e.rw = m_rw;
    e.busy = m_busy;
    if (push) exp_q.push_back(e);
  endtask

  task automatic bus(input bit s, input bit d, input int hold, input bit counted);
    if (counted) model_edge(cur_scl, cur_sda, s, d);
    scl_i = s; sda_i = d; cur_scl = s; cur_sda = d;
    repeat (hold) @(negedge pclk);
  endtask

  task automatic do_start();
    if (!cur_scl) begin
      bus(0, 1, Q, 1);
      bus(1, 1, H, 1);
    end
    bus(1, 0, H, 1);
    bus(0, 0, Q, 1);
  endtask

  task automatic do_stop();
    bus(0, 0, Q, 1);
    bus(1, 0, H, 1);
    bus(1, 1, H, 1);
  endtask

  task automatic send_bit(input bit b);
    bus(0, b, Q, 1);
    bus(1, b, H, 1);
    bus(0, b, Q, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ack);
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (3 * H) @(negedge pclk);
    check_val($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_time%0d", tag, i), obs_q[i].t, exp_q[i].t);
      check_val($sformatf("%s_flags%0d", tag, i),
                {obs_q[i].start, obs_q[i].rstart, obs_q[i].stop, obs_q[i].bv, obs_q[i].err},
                {exp_q[i].start, exp_q[i].rstart, exp_q[i].stop, exp_q[i].bv, exp_q[i].err});
      check_val($sformatf("%s_busy%0d", tag, i), obs_q[i].busy, exp_q[i].busy);
      if (exp_q[i].bv) begin
        check_val($sformatf("%s_byte%0d", tag, i), obs_q[i].data, exp_q[i].data);
        check_val($sformatf("%s_isaddr%0d", tag, i), obs_q[i].is_addr, exp_q[i].is_addr);
        check_val($sformatf("%s_ack%0d", tag, i), obs_q[i].ack, exp_q[i].ack);
        check_val($sformatf("%s_rw%0d", tag, i), obs_q[i].rw, exp_q[i].rw);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [15:0] all_outs();
    return {start_o, rstart_o, stop_o, byte_valid_o, byte_o, is_addr_o, rw_o, ack_o,
            bus_err_o, busy_o};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nbits, g;
    presetn = 1'b0; scl_i = 1'b1; sda_i = 1'b1; cur_scl = 1; cur_sda = 1;
    repeat (3) @(negedge pclk);
    check_val("reset_outs", all_outs(), 16'h0);
    presetn = 1'b1;
    repeat (10) @(negedge pclk);
    check_val("idle_outs", all_outs(), 16'h0);

    do_start(); send_byte(8'hA0, 0); send_byte(8'h5A, 0); do_stop();
    compare_events("wr");

    do_start(); send_byte(8'hA1, 0); send_byte(8'h3C, 1); do_stop();
    compare_events("rd");

    do_start(); send_byte(8'hA0, 0); do_start(); send_byte(8'hA1, 0); do_stop();
    compare_events("rstart");

    bus(1, 0, 2, 0); bus(1, 1, H, 0);
    compare_events("glitch2");
    bus(1, 0, 4, 1); bus(1, 1, H, 1);
    compare_events("glitch4");
    for (int k = 0; k < 4; k++) begin
      g = $urandom_range(1, FL - 1);
      bus(1, 0, g, 0); bus(1, 1, H, 0);
      g = $urandom_range(FL, FL + 4);
      bus(1, 0, g, 1); bus(1, 1, H, 1);
      compare_events($sformatf("glitch_rnd%0d", k));
    end

    do_start();
    for (int k = 0; k < 4; k++) send_bit(1'($urandom));
    do_stop();
    compare_events("err4");

    do_start();
    for (int k = 0; k < 4; k++) send_bit(1'($urandom));
    bus(0, 1, Q, 1);
    compare_events("pre_rst");
    presetn = 1'b0;
    m_busy = 0; m_pend = 0; m_addr = 0; m_rw = 0; bitq.delete();
    #1;
    check_val("midrst_outs0", all_outs(), 16'h0);
    @(negedge pclk);
    check_val("midrst_outs1", all_outs(), 16'h0);
    @(negedge pclk);
    check_val("midrst_outs2", all_outs(), 16'h0);
    presetn = 1'b1;
    repeat (6) @(negedge pclk);
    for (int k = 0; k < 4; k++) send_bit(1'($urandom));
    bus(0, 1, Q, 1);
    compare_events("post_rst");
    check_val("post_rst_byte", byte_o, 8'h00);
    do_start(); send_byte(8'($urandom), 0); do_stop();
    compare_events("fresh");

    for (int it = 0; it < 8; it++) begin
      do_start();
      send_byte({7'($urandom), 1'($urandom)}, 0);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) send_byte(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        nbits = $urandom_range(1, 8);
        for (int k = 0; k < nbits; k++) send_bit(1'($urandom));
      end
      if ($urandom_range(0, 1) == 0) do_stop();
      compare_events($sformatf("rnd%0d", it));
    end
    do_stop();
    compare_events("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
